uart_tx_param: RTL

- Parametrised successor to the fixed 8N1 UART transmitter.
- Configurable data width, parity mode and stop-bit count.
- Valid/ready input handshake, and a baud counter that restarts at the start of each frame, so the start bit has an exact width.
- Sits between the byte-producing logic (command/status formatter) and the tx pin.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 78 +++++++
 rtl/uart_tx_param.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the parametrised UART transmitter.
//   parity_e     : parity mode encoding (none / odd / even)
//   tx_state_e   : transmitter FSM states
//   clks_per_bit : integer clock-cycles-per-bit from clock and baud rates
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous single-clock FIFO feeding the transmitter FSM.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset (empties the FIFO)
//   i_push  in   write i_din (ignored when full)
//   i_pop   in   drop the head entry (ignored when empty)
//   i_din   in   WIDTH-bit write data
//   o_dout  out  head entry, valid whenever o_empty is low
//   o_full  out  DEPTH entries stored
//   o_empty out  no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // NOTE: storage is deliberately left out of reset; only the pointers and
    // count define what is valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: configurable data width, parity and stop
// bits, valid/ready input handshake. The baud counter restarts with every
// frame so the start bit is exactly CLKS_PER_BIT cycles wide.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   s_valid  in   producer has a word on s_data
//   s_ready  out  word on s_data is taken on this edge when s_valid is high
//   s_data   in   DATA_BITS payload, sent LSB first
//   tx       out  serial line, idle high
//   busy     out  high while a frame is on the line
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO
// between s_* and the FSM (s_ready then means "FIFO not full").
// -----------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CPB - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    // ---------------------------------------------------------------- checks
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CPB < 4) begin : g_bad_cpb
            $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    // ----------------------------------------------------------- signals
    tx_state_e            r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_rdy;       // FSM can take a word on this edge

    logic                 w_src_valid;
    logic [DATA_BITS-1:0] w_src_data;
    logic                 w_take;
    logic                 w_bit_end;
    logic                 w_par_in;

    // --------------------------------------------------------- input path
`ifdef UART_TX_FIFO_EN
    logic w_full;
    logic w_empty;
    logic r_live;                      // holds s_ready low while in reset

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (s_valid && s_ready),
        .i_pop   (w_take),
        .i_din   (s_data),
        .o_dout  (w_src_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_ready     = r_live && !w_full;
    assign w_src_valid = !w_empty;
`else
    assign s_ready     = r_rdy;
    assign w_src_valid = s_valid;
    assign w_src_data  = s_data;
`endif

    // r_rdy is only ever high in IDLE or in the final cycle of the last
    // stop bit, so a take always starts a fresh frame.
    assign w_take    = w_src_valid && r_rdy;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_par_in  = (PARITY == int'(PAR_EVEN)) ? ^w_src_data : ~^w_src_data;

    assign tx   = r_tx;
    assign busy = r_busy;

    // ----------------------------------------------------------------- FSM
    // NOTE: every register here is updated with <= so all next-state terms
    // see the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_rdy     <= 1'b0;
        end else if (w_take) begin
            // Capture and drive the start bit on the same edge so a
            // back-to-back frame follows the last stop cycle with no gap.
            r_state   <= START;
            r_shreg   <= w_src_data;
            r_par     <= w_par_in;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_rdy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_rdy  <= 1'b1;
                end

                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shreg[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == DATA_LAST) begin
                            r_bit_idx <= '0;
                            if (PARITY != int'(PAR_NONE)) begin
                                r_state <= PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            // Next bit is shreg[1]; drive it alongside the shift.
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shreg   <= r_shreg >> 1;
                            r_tx      <= r_shreg[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                PAR: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end && r_bit_idx == STOP_LAST) begin
                        r_state   <= IDLE;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_busy    <= 1'b0;
                        r_rdy     <= 1'b1;
                    end else if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        // Open the back-to-back slot for the final stop cycle.
                        r_rdy  <= (r_bit_idx == STOP_LAST) && (r_baud == BAUD_PRE);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
